// File: rtl/fb_scroll_controller.sv
// Framebuffer port-A owner: arbitrates the RAM between CPU accesses and a
// fill/scroll engine that clears the screen or scrolls the text up one row.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no operation; waiting for a start command
// S_FILL    | write FILL word to idx on each engine grant
// S_SCR_RD  | read word one row below idx on engine grant
// S_SCR_CAP | capture ram_q into hold (no grant needed)
// S_SCR_WR  | write hold to idx on engine grant
// S_FINISH  | one-cycle done pulse, busy already low
module fb_scroll_controller #(
  parameter int COLS = 80,
  parameter int ROWS = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fb_cs,
  input  logic        fb_access,
  output logic        fb_ack,
  input  logic [10:0] fb_addr,
  input  logic        fb_wr_en,
  input  logic [15:0] fb_data_in,
  input  logic [1:0]  fb_bytesel,
  output logic [15:0] fb_data_out,
  input  logic        ctl_cs,
  input  logic        ctl_access,
  output logic        ctl_ack,
  input  logic        ctl_addr,
  input  logic        ctl_wr_en,
  input  logic [15:0] ctl_data_in,
  output logic [15:0] ctl_data_out,
  output logic [10:0] ram_addr,
  output logic [15:0] ram_data,
  output logic [1:0]  ram_bytesel,
  output logic        ram_wren,
  input  logic [15:0] ram_q,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SCR_RD, S_SCR_CAP, S_SCR_WR, S_FINISH
  } state_t;

  localparam logic [10:0] COLS_A     = 11'(COLS);
  localparam logic [10:0] LAST_A     = 11'(COLS * ROWS - 1);
  localparam logic [10:0] SCR_LAST_A = 11'(COLS * (ROWS - 1) - 1);
  localparam logic [10:0] BOTTOM_A   = 11'(COLS * (ROWS - 1));

  state_t      state, state_nxt;
  logic [10:0] idx, idx_nxt;
  logic [15:0] hold, hold_nxt;
  logic [15:0] fill_reg;
  logic [15:0] ctl_rdata;
  logic        fb_rd_ack;
  logic        cpu_req, cpu_grant, eng_want, eng_grant;
  logic        ctl_req, cmd_wr, start_fill, start_scroll;

  // The ack cycle masks the CPU request, so the CPU never wins two cycles
  // running; the busy term keeps the engine's slot explicit regardless.
  assign cpu_req      = fb_access & fb_cs & ~fb_ack;
  assign cpu_grant    = cpu_req & ~(busy & fb_ack);
  assign eng_want     = (state == S_FILL) | (state == S_SCR_RD) | (state == S_SCR_WR);
  assign eng_grant    = eng_want & ~cpu_grant;
  assign ctl_req      = ctl_access & ctl_cs & ~ctl_ack;
  assign cmd_wr       = ctl_req & ctl_wr_en & ~ctl_addr & ~busy;
  assign start_fill   = cmd_wr & ctl_data_in[0];
  assign start_scroll = cmd_wr & ctl_data_in[1] & ~ctl_data_in[0];

  // Engine state and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      idx   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      hold  <= hold_nxt;
    end
  end

  // Engine next-state and index/hold update.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    hold_nxt  = hold;
    case (state)
      S_IDLE, S_FINISH: begin
        if (start_fill) begin
          state_nxt = S_FILL;
          idx_nxt   = '0;
        end else if (start_scroll) begin
          state_nxt = S_SCR_RD;
          idx_nxt   = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        if (eng_grant) begin
          idx_nxt = idx + 11'd1;
          if (idx == LAST_A) state_nxt = S_FINISH;
        end
      end
      S_SCR_RD: begin
        if (eng_grant) state_nxt = S_SCR_CAP;
      end
      S_SCR_CAP: begin
        // ram_q carries the engine's read even if the CPU owns this cycle.
        hold_nxt  = ram_q;
        state_nxt = S_SCR_WR;
      end
      S_SCR_WR: begin
        if (eng_grant) begin
          if (idx == SCR_LAST_A) begin
            state_nxt = S_FILL;
            idx_nxt   = BOTTOM_A;
          end else begin
            state_nxt = S_SCR_RD;
            idx_nxt   = idx + 11'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs and the RAM port mux driven from the grant decision.
  always_comb begin
    busy        = (state != S_IDLE) && (state != S_FINISH);
    done        = (state == S_FINISH);
    ram_addr    = '0;
    ram_data    = '0;
    ram_bytesel = '0;
    ram_wren    = 1'b0;
    if (cpu_grant) begin
      ram_addr    = fb_addr;
      ram_data    = fb_data_in;
      ram_bytesel = fb_bytesel;
      ram_wren    = fb_wr_en;
    end else if (eng_grant) begin
      case (state)
        S_FILL: begin
          ram_addr    = idx;
          ram_data    = fill_reg;
          ram_bytesel = 2'b11;
          ram_wren    = 1'b1;
        end
        S_SCR_RD: begin
          ram_addr = idx + COLS_A;
        end
        S_SCR_WR: begin
          ram_addr    = idx;
          ram_data    = hold;
          ram_bytesel = 2'b11;
          ram_wren    = 1'b1;
        end
        default: ram_addr = '0;
      endcase
    end
  end

  // CPU/control acks, control read capture and the FILL register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_ack    <= 1'b0;
      fb_rd_ack <= 1'b0;
      ctl_ack   <= 1'b0;
      ctl_rdata <= '0;
      fill_reg  <= 16'h0720;
    end else begin
      fb_ack    <= cpu_grant;
      fb_rd_ack <= cpu_grant & ~fb_wr_en;
      ctl_ack   <= ctl_req;
      if (ctl_req) ctl_rdata <= ctl_wr_en ? 16'h0000 : (ctl_addr ? fill_reg : {15'b0, busy});
      if (ctl_req && ctl_wr_en && ctl_addr && !busy) fill_reg <= ctl_data_in;
    end
  end

  assign fb_data_out  = fb_rd_ack ? ram_q : 16'h0000;
  assign ctl_data_out = ctl_ack ? ctl_rdata : 16'h0000;

endmodule

// File: tb/tb_fb_scroll_controller.sv
// Directed bench for fb_scroll_controller with a behavioural port-A RAM.
module tb_fb_scroll_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fb_cs, fb_access, fb_ack, fb_wr_en;
  logic [10:0] fb_addr;
  logic [15:0] fb_data_in, fb_data_out;
  logic [1:0]  fb_bytesel;
  logic        ctl_cs, ctl_access, ctl_ack, ctl_addr, ctl_wr_en;
  logic [15:0] ctl_data_in, ctl_data_out;
  logic [10:0] ram_addr;
  logic [15:0] ram_data, ram_q;
  logic [1:0]  ram_bytesel;
  logic        ram_wren, busy, done;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:2047];
  logic [10:0] waddr_q[$];
  logic [15:0] wdata_q[$];
  logic [1:0]  wbe_q[$];
  int          done_cnt = 0;
  int          busy_cyc = 0;

  fb_scroll_controller #(.COLS(80), .ROWS(25)) dut (
    .clk(clk), .reset_n(reset_n),
    .fb_cs(fb_cs), .fb_access(fb_access), .fb_ack(fb_ack), .fb_addr(fb_addr),
    .fb_wr_en(fb_wr_en), .fb_data_in(fb_data_in), .fb_bytesel(fb_bytesel),
    .fb_data_out(fb_data_out),
    .ctl_cs(ctl_cs), .ctl_access(ctl_access), .ctl_ack(ctl_ack), .ctl_addr(ctl_addr),
    .ctl_wr_en(ctl_wr_en), .ctl_data_in(ctl_data_in), .ctl_data_out(ctl_data_out),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_bytesel(ram_bytesel),
    .ram_wren(ram_wren), .ram_q(ram_q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM model with one-cycle read latency plus write/done/busy logging.
  always @(posedge clk) begin
    if (ram_wren) begin
      if (ram_bytesel[0]) mem[ram_addr][7:0]  <= ram_data[7:0];
      if (ram_bytesel[1]) mem[ram_addr][15:8] <= ram_data[15:8];
      waddr_q.push_back(ram_addr);
      wdata_q.push_back(ram_data);
      wbe_q.push_back(ram_bytesel);
    end
    ram_q <= mem[ram_addr];
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] pat(input int a);
    return 16'(((a / 80) << 8) | (a % 80));
  endfunction

  function automatic logic [15:0] exp_scroll(input int a);
    return (a < 1920) ? pat(a + 80) : 16'h1F41;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fb_xfer(input logic wr, input logic [10:0] a, input logic [15:0] d,
                         input logic [1:0] be, output logic [15:0] rd, output int lat);
    int n;
    n = 0;
    fb_cs = 1'b1; fb_access = 1'b1; fb_wr_en = wr;
    fb_addr = a; fb_data_in = d; fb_bytesel = be;
    do begin
      @(posedge clk); #1; n++;
    end while (!fb_ack && n < 20);
    lat = fb_ack ? n : 99;
    rd = fb_data_out;
    fb_access = 1'b0; fb_cs = 1'b0; fb_wr_en = 1'b0;
  endtask

  task automatic ctl_xfer(input logic a, input logic wr, input logic [15:0] d,
                          output logic [15:0] rd, output int lat);
    int n;
    n = 0;
    ctl_cs = 1'b1; ctl_access = 1'b1; ctl_addr = a; ctl_wr_en = wr; ctl_data_in = d;
    do begin
      @(posedge clk); #1; n++;
    end while (!ctl_ack && n < 20);
    lat = ctl_ack ? n : 99;
    rd = ctl_data_out;
    ctl_access = 1'b0; ctl_cs = 1'b0; ctl_wr_en = 1'b0;
  endtask

  task automatic preload();
    logic [15:0] rd;
    int lat;
    for (int a = 0; a < 2000; a++) fb_xfer(1'b1, 11'(a), pat(a), 2'b11, rd, lat);
    for (int k = 0; k < 8; k++) fb_xfer(1'b1, 11'(2040 + k), 16'hBE00 + 16'(k), 2'b11, rd, lat);
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] rd;
    int lat;
    reset_n = 1'b0;
    fb_cs = 0; fb_access = 0; fb_addr = 0; fb_wr_en = 0; fb_data_in = 0; fb_bytesel = 0;
    ctl_cs = 0; ctl_access = 0; ctl_addr = 0; ctl_wr_en = 0; ctl_data_in = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (fb_ack !== 1'b0) begin errors++; $display("FAIL reset_fb_ack: got %b want 0", fb_ack); end
    checks++; if (ctl_ack !== 1'b0) begin errors++; $display("FAIL reset_ctl_ack: got %b want 0", ctl_ack); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    checks++; if (ram_wren !== 1'b0 || ram_addr !== 11'd0) begin errors++; $display("FAIL reset_ram: got wren=%b addr=%0d want 0/0", ram_wren, ram_addr); end
    reset_n = 1'b1;
    tick();
    ctl_xfer(1'b1, 1'b0, 16'h0, rd, lat);
    checks++; if (lat !== 1 || rd !== 16'h0720) begin errors++; $display("FAIL reset_fill_read: got lat=%0d data=%h want 1/0720", lat, rd); end
    tick();
    ctl_xfer(1'b0, 1'b0, 16'h0, rd, lat);
    checks++; if (rd !== 16'h0000 || busy !== 1'b0) begin errors++; $display("FAIL reset_cmd_read: got %h busy=%b want 0000/0", rd, busy); end
    tick();
    checks++; if (ctl_ack !== 1'b0 || ctl_data_out !== 16'h0000) begin errors++; $display("FAIL ctl_idle_out: got ack=%b data=%h want 0/0000", ctl_ack, ctl_data_out); end
  endtask

  task automatic test_fb_rw();
    logic [15:0] rd;
    int lat;
    fb_cs = 1; fb_access = 1; fb_wr_en = 1; fb_addr = 11'd5; fb_data_in = 16'hABCD; fb_bytesel = 2'b11;
    #1;
    checks++;
    if (ram_wren !== 1'b1 || ram_addr !== 11'd5 || ram_bytesel !== 2'b11 || ram_data !== 16'hABCD) begin
      errors++; $display("FAIL fb_write_grant: got wren=%b addr=%0d be=%b data=%h want 1/5/11/abcd", ram_wren, ram_addr, ram_bytesel, ram_data);
    end
    @(posedge clk); #1;
    checks++; if (fb_ack !== 1'b1) begin errors++; $display("FAIL fb_write_ack: got %b want 1", fb_ack); end
    fb_access = 0; fb_cs = 0; fb_wr_en = 0;
    tick();
    fb_xfer(1'b0, 11'd5, 16'h0, 2'b11, rd, lat);
    checks++; if (lat !== 1 || rd !== 16'hABCD) begin errors++; $display("FAIL fb_readback: got lat=%0d data=%h want 1/abcd", lat, rd); end
    tick();
    checks++; if (fb_ack !== 1'b0 || fb_data_out !== 16'h0000) begin errors++; $display("FAIL fb_idle_out: got ack=%b data=%h want 0/0000", fb_ack, fb_data_out); end
    fb_xfer(1'b1, 11'd5, 16'h1234, 2'b01, rd, lat);
    tick();
    fb_xfer(1'b0, 11'd5, 16'h0, 2'b11, rd, lat);
    checks++; if (rd !== 16'hAB34) begin errors++; $display("FAIL fb_bytesel: got %h want ab34", rd); end
    tick();
  endtask

  task automatic test_fill();
    logic [15:0] rd;
    int lat, w0, d0, b0, bad, found;
    ctl_xfer(1'b1, 1'b1, 16'h1F41, rd, lat);
    w0 = waddr_q.size(); d0 = done_cnt; b0 = busy_cyc;
    ctl_xfer(1'b0, 1'b1, 16'h0001, rd, lat);
    ctl_xfer(1'b0, 1'b0, 16'h0, rd, lat);
    checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL fill_busy_read: got %h want 0001", rd); end
    ctl_xfer(1'b1, 1'b1, 16'hDEAD, rd, lat);
    ctl_xfer(1'b0, 1'b1, 16'h0002, rd, lat);
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(posedge clk); #1;
      if (done) found = 1;
    end
    checks++; if (found !== 1 || busy !== 1'b0) begin errors++; $display("FAIL fill_done: got seen=%0d busy=%b want 1/0", found, busy); end
    repeat (3) tick();
    checks++; if (waddr_q.size() - w0 !== 2000) begin errors++; $display("FAIL fill_count: got %0d writes want 2000", waddr_q.size() - w0); end
    bad = 0;
    for (int k = 0; k < waddr_q.size() - w0; k++)
      if (waddr_q[w0 + k] !== 11'(k) || wdata_q[w0 + k] !== 16'h1F41 || wbe_q[w0 + k] !== 2'b11) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL fill_sequence: got %0d bad writes want 0", bad); end
    checks++; if (busy_cyc - b0 !== 2000) begin errors++; $display("FAIL fill_back_to_back: got %0d busy cycles want 2000", busy_cyc - b0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL fill_done_once: got %0d pulses want 1", done_cnt - d0); end
    ctl_xfer(1'b1, 1'b0, 16'h0, rd, lat);
    checks++; if (rd !== 16'h1F41) begin errors++; $display("FAIL fill_write_ignored: got %h want 1f41", rd); end
    tick();
  endtask

  task automatic test_scroll();
    logic [15:0] rd;
    int lat, d0, w0, bad;
    preload();
    d0 = done_cnt; w0 = waddr_q.size();
    ctl_xfer(1'b0, 1'b1, 16'h0002, rd, lat);
    for (int i = 0; i < 8000 && busy; i++) tick();
    repeat (3) tick();
    checks++; if (done_cnt - d0 !== 1 || busy !== 1'b0) begin errors++; $display("FAIL scroll_done: got pulses=%0d busy=%b want 1/0", done_cnt - d0, busy); end
    checks++; if (waddr_q.size() - w0 !== 2000) begin errors++; $display("FAIL scroll_count: got %0d writes want 2000", waddr_q.size() - w0); end
    checks++; if (mem[0] !== 16'h0100) begin errors++; $display("FAIL scroll_word0: got %h want 0100", mem[0]); end
    checks++; if (mem[1919] !== 16'h184F) begin errors++; $display("FAIL scroll_word1919: got %h want 184f", mem[1919]); end
    checks++; if (mem[1920] !== 16'h1F41 || mem[1999] !== 16'h1F41) begin errors++; $display("FAIL scroll_bottom: got %h %h want 1f41", mem[1920], mem[1999]); end
    bad = 0;
    for (int a = 0; a < 2000; a++) if (mem[a] !== exp_scroll(a)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL scroll_image: got %0d bad words want 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd;
    int lat, d0, b0, k, maxlat, bad;
    preload();
    d0 = done_cnt; b0 = busy_cyc;
    ctl_xfer(1'b0, 1'b1, 16'h0002, rd, lat);
    k = 0; maxlat = 0; bad = 0;
    while (busy && k < 8000) begin
      fb_xfer(1'b0, 11'(2040 + (k % 8)), 16'h0, 2'b11, rd, lat);
      if (lat > maxlat) maxlat = lat;
      if (rd !== 16'hBE00 + 16'(k % 8)) bad++;
      k++;
    end
    repeat (3) tick();
    checks++; if (maxlat > 2) begin errors++; $display("FAIL cpu_latency: got max %0d cycles want <=2", maxlat); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL cpu_read_data: got %0d bad reads want 0", bad); end
    checks++; if (2 * k + 4 < busy_cyc - b0 || k < 1000) begin errors++; $display("FAIL alternation: got %0d reads in %0d busy cycles want about half", k, busy_cyc - b0); end
    checks++; if (done_cnt - d0 !== 1 || busy_cyc - b0 > 9000) begin errors++; $display("FAIL contended_done: got pulses=%0d busy_cycles=%0d want 1/<=9000", done_cnt - d0, busy_cyc - b0); end
    bad = 0;
    for (int a = 0; a < 2000; a++) if (mem[a] !== exp_scroll(a)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL contended_image: got %0d bad words want 0", bad); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] rd;
    int lat, found, bad;
    ctl_xfer(1'b1, 1'b1, 16'h2222, rd, lat);
    ctl_xfer(1'b0, 1'b1, 16'h0003, rd, lat);
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      if (ram_wren && ram_addr == 11'd1000) found = 1;
      else tick();
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL abort_reach_1000: got seen=%0d want 1", found); end
    reset_n = 1'b0;
    #1;
    checks++; if (ram_wren !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_immediate: got wren=%b busy=%b want 0/0", ram_wren, busy); end
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    checks++; if (mem[0] !== 16'h2222 || mem[999] !== 16'h2222) begin errors++; $display("FAIL abort_low_part: got %h %h want 2222", mem[0], mem[999]); end
    bad = 0;
    for (int a = 1000; a < 2000; a++) if (mem[a] !== exp_scroll(a)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort_no_writes: got %0d overwritten words want 0", bad); end
    ctl_xfer(1'b1, 1'b0, 16'h0, rd, lat);
    checks++; if (rd !== 16'h0720 || busy !== 1'b0) begin errors++; $display("FAIL abort_fill_reset: got %h busy=%b want 0720/0", rd, busy); end
  endtask

  initial begin
    test_reset();
    test_fb_rw();
    test_fill();
    test_scroll();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_scroll_controller.md
Name: fb_scroll_controller

Overview:
- Owns the CPU-side port of the text-mode framebuffer RAM. Arbitrates it between CPU bus accesses and an internal fill/scroll engine.
- The engine clears the screen to a fill word, or scrolls the text up one row and blanks the bottom row, without CPU copy loops.
- Sits between the CPU data bus and the framebuffer dual-port RAM port A. The VGA read port B is untouched.

Parameters:
- COLS, 80, characters per row.
- ROWS, 25, rows per screen; COLS*ROWS must be at most 2048.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- fb_cs  input  1  CPU framebuffer chip select.
- fb_access  input  1  CPU framebuffer request; held until fb_ack.
- fb_ack  output  1  one-cycle ack for a framebuffer access.
- fb_addr  input  11  CPU word address into the framebuffer.
- fb_wr_en  input  1  CPU write (1) or read (0).
- fb_data_in  input  16  CPU write data.
- fb_bytesel  input  2  CPU byte enables.
- fb_data_out  output  16  CPU read data; 0 when fb_ack=0.
- ctl_cs  input  1  control register chip select.
- ctl_access  input  1  control register request.
- ctl_ack  output  1  one-cycle ack for a control access.
- ctl_addr  input  1  0 = CMD/STATUS, 1 = FILL.
- ctl_wr_en  input  1  control write.
- ctl_data_in  input  16  control write data.
- ctl_data_out  output  16  control read data; 0 when ctl_ack=0.
- ram_addr  output  11  RAM port A address.
- ram_data  output  16  RAM port A write data.
- ram_bytesel  output  2  RAM port A byte enables.
- ram_wren  output  1  RAM port A write enable.
- ram_q  input  16  RAM port A read data, valid 1 cycle after address.
- busy  output  1  engine operation in progress.
- done  output  1  one-cycle pulse when an engine operation completes.

Behaviour:
- Reset values: fb_ack=0, ctl_ack=0, busy=0, done=0, ram_wren=0, ram_addr=0, engine in IDLE, FILL register=16'h0720 (grey-on-black space).
- RAM port is combinational from the grant decision. Exactly one requester (CPU or engine) is granted per cycle.
- CPU framebuffer path:
  - A request is fb_access & fb_cs & no ack in the current cycle.
  - When granted, fb_ack=1 on the next cycle; for a read, fb_data_out=ram_q in that ack cycle.
  - The CPU is never granted two consecutive cycles; the ack cycle is a bubble for the CPU.
- Arbitration: CPU has priority, except when busy=1 and the CPU was granted in the previous cycle; then the engine gets the slot. The engine is guaranteed at least 1 of every 2 cycles.
- Control path:
  - ctl_ack=1 the cycle after ctl_access & ctl_cs. There is no RAM involvement.
  - CMD read returns {15'b0, busy}. FILL read returns the FILL register.
  - CMD write: bit0 = start FILL, bit1 = start SCROLL; both set means FILL. Ignored while busy=1.
  - FILL write is ignored while busy=1.
- Engine states:
  - IDLE: on a start command, set busy=1 the next cycle and go to FILL (idx=0) or SCR_RD (idx=0).
  - FILL: on each engine grant, write FILL to idx with bytesel 2'b11 and idx++. After the write at idx=COLS*ROWS-1, go to FINISH.
  - SCR_RD: on grant, read address idx+COLS; go to SCR_CAP.
  - SCR_CAP: unconditionally capture ram_q into a hold register; no grant needed. Go to SCR_WR.
  - SCR_WR: on grant, write hold to idx and idx++. If idx was COLS*(ROWS-1)-1, go to FILL with idx=COLS*(ROWS-1); else go to SCR_RD.
  - FINISH: busy=0, done=1 for one cycle, then IDLE.
- While the engine is in SCR_CAP, the CPU may be granted in the same cycle. The capture still uses the engine's read data, because the CPU address is applied this cycle and its data returns next cycle.
- CPU writes during an operation are allowed and unordered relative to the engine; software polls busy.
- Index arithmetic is 11-bit unsigned with no wrap; the engine never addresses at or above COLS*ROWS.
- Asserting reset_n low mid-operation aborts immediately: no further RAM writes, acks cleared, FILL returns to 16'h0720.

Test Plan:
- Reset, then read ctl_addr=1 -> ctl_ack next cycle, ctl_data_out=16'h0720; busy=0.
- CPU write 16'hABCD to fb_addr=5, then read it back -> ram_wren at addr 5 with bytesel 11; read ack returns 16'hABCD.
- Write FILL=16'h1F41, CMD=1 with no CPU traffic -> 2000 consecutive writes at addresses 0..1999; done pulses once; busy low after.
- Preload row r with value r*256+col, CMD=2 -> word at addr 0 = 16'h0100; addr 1920..1999 = FILL; done pulses once.
- During a scroll, hold fb_access continuously with reads -> CPU and engine alternate grants; the scroll still completes correctly and every CPU read acks within 2 cycles.
- Assert reset_n low at write index 1000 of a FILL -> ram_wren=0 immediately; busy=0; addresses at and above 1000 are not written after reset.
